// File: rtl/instr_fetch_rv_pkg.sv
// instr_fetch_rv_pkg: shared encodings and helpers for the fetch stage
package instr_fetch_rv_pkg;
  localparam logic [1:0] NEXT_PC_SRC_SEQ  = 2'd0;
  localparam logic [1:0] NEXT_PC_SRC_B    = 2'd1;
  localparam logic [1:0] NEXT_PC_SRC_JAL  = 2'd2;
  localparam logic [1:0] NEXT_PC_SRC_JALR = 2'd3;
  localparam logic [31:0] RISCV_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {
    FETCH_STATE_FETCH = 2'd0,
    FETCH_STATE_HOLD  = 2'd1,
    FETCH_STATE_FAULT = 2'd2
  } fetch_state_t;
  function automatic logic [31:0] sign_extend_12_32(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction
endpackage

// File: rtl/instr_fetch_rv_if.sv
// instr_fetch_rv_if: instruction memory request/acknowledge bus
interface instr_fetch_rv_if;
  logic        owIMemReq;
  logic [31:0] owIMemAddr;
  logic        iwIMemAck;
  logic [31:0] iwIMemData;
  modport master (output owIMemReq, output owIMemAddr, input iwIMemAck, input iwIMemData);
  modport slave  (input owIMemReq, input owIMemAddr, output iwIMemAck, output iwIMemData);
endinterface

// File: rtl/next_pc_rv.sv
// next_pc_rv: combinational next-PC target and misalignment check
module next_pc_rv
  import instr_fetch_rv_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_src,
  input  logic [19:0] i_imm20,
  input  logic [11:0] i_imm12,
  input  logic        i_taken,
  input  logic [31:0] i_jalr_base,
  output logic [31:0] o_target,
  output logic        o_misaligned
);
  logic [31:0] w_seq, w_jal, w_br, w_jalr;
  assign w_seq  = i_pc + 32'd4;
  assign w_jal  = i_pc + {{11{i_imm20[19]}}, i_imm20, 1'b0};
  assign w_br   = i_pc + {{19{i_imm12[11]}}, i_imm12, 1'b0};
  assign w_jalr = (i_jalr_base + sign_extend_12_32(i_imm12)) & ~32'h1;
  assign o_target = i_src == NEXT_PC_SRC_SEQ ? w_seq :
                    i_src == NEXT_PC_SRC_B   ? (i_taken ? w_br : w_seq) :
                    i_src == NEXT_PC_SRC_JAL ? w_jal : w_jalr;
  assign o_misaligned = |o_target[1:0];
endmodule

// File: rtl/instr_fetch_rv.sv
// instr_fetch_rv: single-outstanding RV32I instruction fetch stage
module instr_fetch_rv
  import instr_fetch_rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             iwClk,
  input  logic             iwnRst,
  instr_fetch_rv_if.master imem,
  output logic [31:0]      owInstr,
  output logic [31:0]      owPc,
  output logic             owInstrValid,
  input  logic             iwAdvance,
  input  logic [1:0]       iwNextPcSrc,
  input  logic [19:0]      iwNextPcImmediate20,
  input  logic [11:0]      iwNextPcImmediate12,
  input  logic             iwBranchTaken,
  input  logic [31:0]      iwJalrBase,
  input  logic             iwnIllegal,
  output logic             owFault
);
  fetch_state_t r_state, w_next;
  logic [31:0] r_pc, r_instr, w_target;
  logic w_misaligned, w_capture, w_retire;

  next_pc_rv u_next_pc (
    .i_pc        (r_pc),
    .i_src       (iwNextPcSrc),
    .i_imm20     (iwNextPcImmediate20),
    .i_imm12     (iwNextPcImmediate12),
    .i_taken     (iwBranchTaken),
    .i_jalr_base (iwJalrBase),
    .o_target    (w_target),
    .o_misaligned(w_misaligned)
  );

  // FSM state register
  always_ff @(posedge iwClk or negedge iwnRst)
    if (!iwnRst) r_state <= FETCH_STATE_FETCH;
    else r_state <= w_next;

  // next state and handshake outputs; request is masked while reset is held
  always_comb begin
    w_next = r_state;
    w_capture = 1'b0;
    w_retire = 1'b0;
    imem.owIMemReq = 1'b0;
    owInstrValid = 1'b0;
    owFault = 1'b0;
    case (r_state)
      FETCH_STATE_FETCH: begin
        imem.owIMemReq = iwnRst;
        w_capture = imem.iwIMemAck;
        w_next = imem.iwIMemAck ? FETCH_STATE_HOLD : FETCH_STATE_FETCH;
      end
      FETCH_STATE_HOLD: begin
        owInstrValid = 1'b1;
        w_retire = iwAdvance && iwnIllegal && !w_misaligned;
        w_next = !iwAdvance ? FETCH_STATE_HOLD : w_retire ? FETCH_STATE_FETCH : FETCH_STATE_FAULT;
      end
      FETCH_STATE_FAULT: owFault = 1'b1;
      default: w_next = FETCH_STATE_FAULT;
    endcase
  end

  assign imem.owIMemAddr = {r_pc[31:2], 2'b00};
  assign owPc = r_pc;
  assign owInstr = owInstrValid ? r_instr : RISCV_NOP;

  // PC advances only on a clean retirement; the fetched word is captured on ack
  always_ff @(posedge iwClk or negedge iwnRst)
    if (!iwnRst) begin
      r_pc <= RESET_PC;
      r_instr <= RISCV_NOP;
    end else begin
      if (w_capture) r_instr <= imem.iwIMemData;
      if (w_retire) r_pc <= w_target;
    end
endmodule

// File: tb/tb_instr_fetch_rv.sv
// tb_instr_fetch_rv: directed and randomized checks of the fetch stage against a reference model
module tb_instr_fetch_rv;
  import instr_fetch_rv_pkg::*;

  logic        iwClk = 1'b0;
  logic        iwnRst = 1'b0;
  logic [31:0] owInstr, owPc;
  logic        owInstrValid, owFault;
  logic        iwAdvance = 1'b0;
  logic [1:0]  iwNextPcSrc = 2'd0;
  logic [19:0] iwNextPcImmediate20 = 20'd0;
  logic [11:0] iwNextPcImmediate12 = 12'd0;
  logic        iwBranchTaken = 1'b0;
  logic [31:0] iwJalrBase = 32'd0;
  logic        iwnIllegal = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_pc;
  logic        m_fault;

  instr_fetch_rv_if imem();

  instr_fetch_rv dut (
    .iwClk              (iwClk),
    .iwnRst             (iwnRst),
    .imem               (imem),
    .owInstr            (owInstr),
    .owPc               (owPc),
    .owInstrValid       (owInstrValid),
    .iwAdvance          (iwAdvance),
    .iwNextPcSrc        (iwNextPcSrc),
    .iwNextPcImmediate20(iwNextPcImmediate20),
    .iwNextPcImmediate12(iwNextPcImmediate12),
    .iwBranchTaken      (iwBranchTaken),
    .iwJalrBase         (iwJalrBase),
    .iwnIllegal         (iwnIllegal),
    .owFault            (owFault)
  );

  always #5 iwClk = ~iwClk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iwClk);
    #1;
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [1:0] src,
      input logic [19:0] i20, input logic [11:0] i12, input logic tk, input logic [31:0] base);
    int j, b;
    j = int'(i20);
    if (j >= 'h80000) j -= 'h100000;
    b = int'(i12);
    if (b >= 'h800) b -= 'h1000;
    case (src)
      NEXT_PC_SRC_SEQ: return pc + 32'd4;
      NEXT_PC_SRC_B:   return tk ? pc + 32'(b * 2) : pc + 32'd4;
      NEXT_PC_SRC_JAL: return pc + 32'(j * 2);
      default:         return (base + 32'(b)) & 32'hFFFF_FFFE;
    endcase
  endfunction

  task automatic check_fetch_idle(input string tag);
    chk({tag, "_req"}, 32'(imem.owIMemReq), 32'd1);
    chk({tag, "_addr"}, imem.owIMemAddr, m_pc);
    chk({tag, "_valid"}, 32'(owInstrValid), 32'd0);
    chk({tag, "_instr"}, owInstr, RISCV_NOP);
    chk({tag, "_fault"}, 32'(owFault), 32'd0);
  endtask

  task automatic check_fault(input string tag);
    chk({tag, "_fault"}, 32'(owFault), 32'd1);
    chk({tag, "_valid"}, 32'(owInstrValid), 32'd0);
    chk({tag, "_req"}, 32'(imem.owIMemReq), 32'd0);
    chk({tag, "_pc"}, owPc, m_pc);
    chk({tag, "_instr"}, owInstr, RISCV_NOP);
  endtask

  task automatic do_reset();
    iwnRst = 1'b0;
    iwAdvance = 1'b0;
    imem.iwIMemAck = 1'b0;
    #1;
    chk("rst_req", 32'(imem.owIMemReq), 32'd0);
    chk("rst_valid", 32'(owInstrValid), 32'd0);
    chk("rst_fault", 32'(owFault), 32'd0);
    chk("rst_instr", owInstr, RISCV_NOP);
    chk("rst_pc", owPc, 32'h0);
    step();
    step();
    iwnRst = 1'b1;
    m_pc = 32'h0;
    m_fault = 1'b0;
    #1;
    check_fetch_idle("post_rst");
  endtask

  task automatic fault_hold(input int n);
    for (int c = 0; c < n; c++) begin
      imem.iwIMemAck = 1'($urandom);
      iwAdvance = 1'($urandom);
      step();
      check_fault("fault_hold");
    end
    imem.iwIMemAck = 1'b0;
    iwAdvance = 1'b0;
  endtask

  task automatic ins(input int lat, input logic [31:0] data, input logic [1:0] src,
      input logic [19:0] i20, input logic [11:0] i12, input logic tk,
      input logic [31:0] base, input logic nill, input int hold);
    logic [31:0] t;
    for (int c = 0; c < lat; c++) begin
      check_fetch_idle("wait");
      iwAdvance = 1'($urandom);
      step();
    end
    check_fetch_idle("ack_cyc");
    imem.iwIMemAck = 1'b1;
    imem.iwIMemData = data;
    iwAdvance = 1'b0;
    step();
    imem.iwIMemAck = 1'b0;
    imem.iwIMemData = $urandom;
    chk("hold_valid", 32'(owInstrValid), 32'd1);
    chk("hold_instr", owInstr, data);
    chk("hold_pc", owPc, m_pc);
    chk("hold_req", 32'(imem.owIMemReq), 32'd0);
    for (int c = 0; c < hold; c++) begin
      imem.iwIMemAck = 1'($urandom);
      iwNextPcSrc = 2'($urandom);
      iwnIllegal = 1'($urandom);
      step();
      chk("stay_valid", 32'(owInstrValid), 32'd1);
      chk("stay_instr", owInstr, data);
      chk("stay_pc", owPc, m_pc);
    end
    imem.iwIMemAck = 1'b0;
    iwNextPcSrc = src;
    iwNextPcImmediate20 = i20;
    iwNextPcImmediate12 = i12;
    iwBranchTaken = tk;
    iwJalrBase = base;
    iwnIllegal = nill;
    iwAdvance = 1'b1;
    t = ref_target(m_pc, src, i20, i12, tk, base);
    if (!nill || t % 4 != 0) m_fault = 1'b1;
    else m_pc = t;
    step();
    iwAdvance = 1'b0;
    iwnIllegal = 1'b1;
    if (m_fault) check_fault("adv_fault");
    else check_fetch_idle("adv");
  endtask

  initial begin
    imem.iwIMemAck = 1'b0;
    imem.iwIMemData = 32'h0;
    m_pc = 32'h0;
    m_fault = 1'b0;
    do_reset();
    ins(3, 32'h0050_0093, NEXT_PC_SRC_JAL, 20'h00080, 12'h0, 1'b0, 32'h0, 1'b1, 1);
    chk("jal_to_100", imem.owIMemAddr, 32'h100);
    ins(1, 32'h0000_0013, NEXT_PC_SRC_SEQ, 20'h0, 12'h0, 1'b0, 32'h0, 1'b1, 0);
    chk("seq_104", imem.owIMemAddr, 32'h104);
    ins(0, 32'h1111_1111, NEXT_PC_SRC_JALR, 20'h0, 12'h0, 1'b0, 32'h100, 1'b1, 0);
    ins(0, 32'h2222_2222, NEXT_PC_SRC_JAL, 20'hFFFFE, 12'h0, 1'b0, 32'h0, 1'b1, 2);
    chk("jal_back_fc", imem.owIMemAddr, 32'hFC);
    ins(2, 32'h3333_3333, NEXT_PC_SRC_JALR, 20'h0, 12'h0, 1'b0, 32'h200, 1'b1, 0);
    ins(0, 32'h4444_4444, NEXT_PC_SRC_B, 20'h0, 12'h008, 1'b1, 32'h0, 1'b1, 0);
    chk("br_taken_210", imem.owIMemAddr, 32'h210);
    ins(0, 32'h5555_5555, NEXT_PC_SRC_JALR, 20'h0, 12'h0, 1'b0, 32'h200, 1'b1, 0);
    ins(1, 32'h6666_6666, NEXT_PC_SRC_B, 20'h0, 12'h008, 1'b0, 32'h0, 1'b1, 0);
    chk("br_not_204", imem.owIMemAddr, 32'h204);
    ins(0, 32'h7777_7777, NEXT_PC_SRC_JALR, 20'h0, 12'h002, 1'b0, 32'h1003, 1'b1, 0);
    chk("jalr_1004", imem.owIMemAddr, 32'h1004);
    ins(0, 32'h8888_8888, NEXT_PC_SRC_JALR, 20'h0, 12'h000, 1'b0, 32'h1001, 1'b1, 0);
    chk("jalr_1000", imem.owIMemAddr, 32'h1000);
    ins(0, 32'h9999_9999, NEXT_PC_SRC_JALR, 20'h0, 12'h000, 1'b0, 32'h1002, 1'b1, 0);
    chk("misalign_pc", owPc, 32'h1000);
    fault_hold(10);
    do_reset();
    ins(0, 32'h0000_0013, NEXT_PC_SRC_JAL, 20'h00020, 12'h0, 1'b0, 32'h0, 1'b1, 0);
    ins(1, 32'hFFFF_FFFF, NEXT_PC_SRC_SEQ, 20'h0, 12'h0, 1'b0, 32'h0, 1'b0, 1);
    chk("illegal_pc", owPc, 32'h40);
    fault_hold(10);
    do_reset();
    ins(0, 32'h0000_0013, NEXT_PC_SRC_JALR, 20'h0, 12'h0, 1'b0, 32'h300, 1'b1, 0);
    step();
    check_fetch_idle("await_300");
    #3;
    iwnRst = 1'b0;
    #1;
    chk("midrst_req", 32'(imem.owIMemReq), 32'd0);
    chk("midrst_pc", owPc, 32'h0);
    imem.iwIMemAck = 1'b1;
    imem.iwIMemData = 32'hDEAD_BEEF;
    step();
    step();
    chk("midrst_valid", 32'(owInstrValid), 32'd0);
    imem.iwIMemAck = 1'b0;
    iwnRst = 1'b1;
    m_pc = 32'h0;
    m_fault = 1'b0;
    #1;
    check_fetch_idle("after_midrst");
    step();
    check_fetch_idle("stale_ack");
    for (int k = 0; k < 60; k++) begin
      logic [19:0] i20;
      logic [11:0] i12;
      logic [31:0] base;
      if (m_fault) do_reset();
      i20 = 20'($urandom);
      i12 = 12'($urandom);
      base = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        i20[0] = 1'b0;
        base[1] = 1'b0;
      end
      ins($urandom_range(0, 3), $urandom, 2'($urandom), i20, i12, 1'($urandom), base,
          1'($urandom_range(0, 9) != 0), $urandom_range(0, 2));
      if (m_fault) fault_hold(2);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_rv.md
# instr_fetch_rv

Single-outstanding instruction fetch stage for the RV32I core. Holds the architectural PC and issues word reads to instruction memory with a request/acknowledge handshake. Presents the fetched word and its PC to `instr_decode_rv` and computes the next PC from that decoder's next-PC controls once the datapath signals retirement. Sits directly upstream of the decoder and drives its `iwInstr` and `iwPc` inputs.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `iwClk`  in  1  sole clock; all state on rising edge.
- `iwnRst`  in  1  asynchronous, active-low reset.
- `owIMemReq`  out  1  fetch request; held until acknowledged.
- `owIMemAddr`  out  32  word address of the fetch (bits [1:0] always 0).
- `iwIMemAck`  in  1  request completes at this edge.
- `iwIMemData`  in  32  instruction word; valid when `iwIMemAck`=1.
- `owInstr`  out  32  instruction to the decoder.
- `owPc`  out  32  PC of `owInstr`.
- `owInstrValid`  out  1  `owInstr`/`owPc` hold a real instruction.
- `iwAdvance`  in  1  datapath retires the presented instruction this cycle.
- `iwNextPcSrc`  in  2  `NEXT_PC_SRC_{SEQ,B,JAL,JALR}` from the decoder.
- `iwNextPcImmediate20`  in  20  J-type imm[20:1].
- `iwNextPcImmediate12`  in  12  B-type imm[12:1], or I-type imm[11:0] for JALR.
- `iwBranchTaken`  in  1  ALU branch result, already XORed with `owBranchInverted`.
- `iwJalrBase`  in  32  rs1 value for JALR.
- `iwnIllegal`  in  1  decoder legality flag (0 = illegal).
- `owFault`  out  1  sticky fault: misaligned target or illegal instruction.

## Operation
- FSM states: FETCH, HOLD, FAULT.
- FETCH:
  - `owIMemReq`=1, `owIMemAddr`=PC.
  - On `iwIMemAck`: capture `iwIMemData`, then go to HOLD.
  - Otherwise stay in FETCH with the address stable.
- HOLD:
  - `owInstrValid`=1; `owInstr` = captured word; `owPc` = PC.
  - On `iwAdvance`=1 with `iwnIllegal`=0: go to FAULT.
  - On `iwAdvance`=1 with a misaligned target (target[1:0]≠0): go to FAULT.
  - On `iwAdvance`=1 otherwise: PC ← target, go to FETCH.
  - On `iwAdvance`=0: hold all outputs.
- FAULT:
  - `owFault`=1, `owIMemReq`=0, `owInstrValid`=0.
  - PC frozen at the faulting instruction.
  - Left only by reset.
- Target computation, all arithmetic modulo 2^32:
  - SEQ: PC+4.
  - JAL: PC + sext({imm20,1'b0}).
  - B, taken: PC + sext({imm12,1'b0}).
  - B, not taken: PC+4.
  - JALR: (iwJalrBase + sext(imm12)) & ~32'h1.
- While `owInstrValid`=0, `owInstr` = 32'h0000_0013 (addi x0,x0,0), so the decoder sees a legal no-op.
- `iwAdvance` is ignored outside HOLD.
- `iwIMemAck` is ignored outside FETCH.

## Timing
- Reset values:
  - state = FETCH; PC = `RESET_PC`.
  - `owIMemReq`=0 while `iwnRst`=0, then 1 from the first cycle after deassertion.
  - `owInstr`=32'h13, `owPc`=`RESET_PC`.
  - `owInstrValid`=0, `owFault`=0.
- Ack latency is unbounded; an ack in the same cycle the request rises is legal.
- Latency:
  - Ack at edge N makes `owInstrValid`=1 in cycle N+1.
  - `iwAdvance` at edge M returns the FSM to FETCH with the new address in cycle M+1.
  - Minimum throughput: 2 cycles per instruction.
- Reset mid-fetch: asynchronously drops `owIMemReq` and clears state. Memory must tolerate an abandoned request; an ack arriving during reset is dropped.
- Simultaneous advance and illegal in HOLD: FAULT takes priority and PC is not updated.

## Structure
- `NEXT_PC_SRC_*` stay in `macros/control_rv.v`.
- Add to the same file:
  - `FETCH_STATE_{FETCH,HOLD,FAULT}` (2-bit encodings).
  - `RISCV_NOP` = 32'h0000_0013.
- One combinational sub-module, `next_pc_rv`:
  - Inputs: PC, source select, both immediates, branch-taken, JALR base.
  - Outputs: 32-bit target and a misaligned flag.
  - Reuses `sign_extend_12_32`.

## Test plan
- Reset with `RESET_PC`=0, ack 3 cycles later, data 32'h00500093 → addr 0 held 3 cycles; then `owInstrValid`=1, `owInstr`=32'h00500093, `owPc`=0.
- SEQ advance at PC 0x100 → next `owIMemAddr`=0x104; zero-latency ack gives `owInstrValid` again 2 cycles after advance.
- JAL at 0x100 with imm20=20'hFFFFE → target 0xFC. Branch at 0x200 with imm12=12'h008: taken → 0x210, not taken → 0x204.
- JALR with base 0x1003, imm12=12'h002 → target 0x1004 (bit0 cleared). Base 0x1001, imm 0 → target 0x1000 (bit0 cleared, not misaligned). Base 0x1002, imm 0 → `owFault`=1, no further requests, PC unchanged.
- Advance with `iwnIllegal`=0 at PC 0x40 → `owFault`=1, `owInstrValid`=0, `owPc`=0x40 sticky across 10 cycles.
- Assert `iwnRst` while in FETCH awaiting ack at 0x300 → `owIMemReq` drops immediately. After release, request at `RESET_PC`; a stale ack during reset is ignored.
